// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive/transmit blocks.
//   - PARITY_NONE / PARITY_ODD / PARITY_EVEN : PARITY_MODE encodings
//   - rx_state_t                             : receiver FSM states
//   - baud_div / baud_div_legal              : oversampling divider and its legality
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Clocks per oversampling tick, truncated; 0 marks an unusable setting.
  function automatic int baud_div(input int clk_freq_hz, input int baud, input int oversample);
    if (baud < 1 || oversample < 1) return 0;
    return clk_freq_hz / (baud * oversample);
  endfunction

  function automatic bit baud_div_legal(input int clk_freq_hz, input int baud, input int oversample);
    return baud_div(clk_freq_hz, baud, oversample) >= 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: enable-gated divider producing a one-clock tick every DIV
// clocks. A synchronous clear restarts the phase so the first tick after
// enabling lands on a known clock.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   en   in  count enable; no ticks while low
//   clr  in  synchronous counter clear
//   tick out one-clock pulse every DIV enabled clocks
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running modulo-DIV counter, held at zero while cleared.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: parametrised UART receiver with its own oversampling tick,
// 3-sample majority voting per bit, configurable data/parity/stop framing and
// a valid/ready holding register carrying per-word error flags.
// Optional feature macro: UART_RX_BREAK_DET_EN (break detection on O_break).
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   I_rx_en         receive enable, looked at only while idle
//   I_rs232_rxd     asynchronous serial line, idle high
//   I_rx_ready      consumer accepts the held word
//   O_rx_valid      holding register contains a word
//   O_rx_data       received word, bit 0 = first data bit on the line
//   O_parity_err    parity mismatch on the held word
//   O_frame_err     a stop bit of the held word was sampled low
//   O_overrun       one-cycle pulse: a completed frame was dropped
//   O_busy          receiver is not idle
//   O_break         one-cycle pulse on a break (macro builds only, else 0)
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 I_rx_en,
  input  logic                 I_rs232_rxd,
  input  logic                 I_rx_ready,
  output logic                 O_rx_valid,
  output logic [DATA_BITS-1:0] O_rx_data,
  output logic                 O_parity_err,
  output logic                 O_frame_err,
  output logic                 O_overrun,
  output logic                 O_busy,
  output logic                 O_break
);

  localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [SW-1:0] SAMP_LO   = SW'(M - 1);
  localparam logic [SW-1:0] SAMP_MID  = SW'(M);
  localparam logic [SW-1:0] SAMP_HI   = SW'(M + 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (!baud_div_legal(CLK_FREQ_HZ, BAUD, OVERSAMPLE)) begin : g_div_check
    $error("uart_rx_core: CLK_FREQ_HZ too low for BAUD*OVERSAMPLE");
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
      (PARITY_MODE > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_param_check
    $error("uart_rx_core: illegal framing parameters");
  end

  rx_state_t state, state_next;

  logic                 rx_sync1, rx_sync2, rx_hist;
  logic                 tick;
  logic [SW-1:0]        samp_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 maj_s0, maj_s1;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_q, frm_err_q;
  logic                 valid_q, perr_q, ferr_q, overrun_q;
  logic [DATA_BITS-1:0] data_q;

  logic fall_edge, bit_center, maj_bit, exp_par, frame_ferr, frame_done, is_break;

  assign fall_edge  = rx_hist && !rx_sync2;
  assign bit_center = tick && (samp_cnt == SAMP_HI);
  // The third vote is the live synced line at tick M+1.
  assign maj_bit    = (maj_s0 & maj_s1) | (maj_s0 & rx_sync2) | (maj_s1 & rx_sync2);
  assign exp_par    = (PARITY_MODE == PARITY_EVEN) ? ^shreg : ~^shreg;
  assign frame_ferr = frm_err_q | ~maj_bit;

  // Oversampling tick only runs during a frame and restarts from zero on
  // every start edge, so bit centres line up with the detected edge.
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .clr  (state == IDLE),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; every decision is taken at the bit-centre vote.
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    case (state)
      IDLE:      if (I_rx_en && fall_edge) state_next = START;
      START:     if (bit_center) state_next = maj_bit ? IDLE : DATA;
      DATA:      if (bit_center && (bit_cnt == BIT_LAST))
                   state_next = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
      PARITY:    if (bit_center) state_next = STOP;
      STOP:      if (bit_center && (stop_cnt == STOP_LAST)) begin
                   frame_done = 1'b1;
                   state_next = frame_ferr ? WAIT_HIGH : IDLE;
                 end
      WAIT_HIGH: if (rx_sync2) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Line synchroniser, sample counters, majority votes and the shift register.
  // Per-frame counters and error accumulators are reset every time we idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync1  <= 1'b1;
      rx_sync2  <= 1'b1;
      rx_hist   <= 1'b1;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      maj_s0    <= 1'b0;
      maj_s1    <= 1'b0;
      shreg     <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      rx_sync1 <= I_rs232_rxd;
      rx_sync2 <= rx_sync1;
      rx_hist  <= rx_sync2;
      if (state == IDLE) begin
        samp_cnt  <= '0;
        bit_cnt   <= '0;
        stop_cnt  <= 1'b0;
        par_err_q <= 1'b0;
        frm_err_q <= 1'b0;
      end else if (tick) begin
        samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
        if (samp_cnt == SAMP_LO)  maj_s0 <= rx_sync2;
        if (samp_cnt == SAMP_MID) maj_s1 <= rx_sync2;
        if (samp_cnt == SAMP_HI) begin
          case (state)
            DATA: begin
              shreg   <= {maj_bit, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
            PARITY: par_err_q <= (maj_bit != exp_par);
            STOP: begin
              if (!maj_bit) frm_err_q <= 1'b1;
              stop_cnt <= stop_cnt + 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic par_bit_q, break_q;

  // A break also needs the raw parity bit low, so keep it around.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE)              par_bit_q <= 1'b0;
    else if (bit_center && state == PARITY) par_bit_q <= maj_bit;
  end

  assign is_break = (shreg == '0) && frame_ferr &&
                    ((PARITY_MODE == PARITY_NONE) || !par_bit_q);

  // Break pulse; the FSM already heads to WAIT_HIGH because of the frame error.
  always_ff @(posedge clk) begin
    if (rst) break_q <= 1'b0;
    else     break_q <= frame_done && is_break;
  end

  assign O_break = break_q;
`else
  assign is_break = 1'b0;
  assign O_break  = 1'b0;
`endif

  // Holding register: a completing frame may load in the same cycle the old
  // word drains; otherwise the new word is dropped and overrun pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (valid_q && I_rx_ready) valid_q <= 1'b0;
      if (frame_done && !is_break) begin
        if (!valid_q || I_rx_ready) begin
          valid_q <= 1'b1;
          data_q  <= shreg;
          perr_q  <= par_err_q;
          ferr_q  <= frame_ferr;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign O_rx_valid   = valid_q;
  assign O_rx_data    = data_q;
  assign O_parity_err = perr_q;
  assign O_frame_err  = ferr_q;
  assign O_overrun    = overrun_q;
  assign O_busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed bench for uart_rx_core. Four receivers with
// different framings (8N1, 8E1, 8O1, 7N2) run at 16 clk per bit. Receiver 0
// also covers handshake, overrun, glitch rejection, break and reset.
// Expectations for the break case follow UART_RX_BREAK_DET_EN.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int CLK_HZ  = 1_600_000;
  localparam int BAUD_HZ = 100_000;
  localparam int OS      = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_en;
  logic       rxd   [4];
  logic       ready [4];
  logic       valid [4];
  logic       perr  [4];
  logic       ferr  [4];
  logic       ovr   [4];
  logic       busy  [4];
  logic       brk   [4];
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;

  int checks = 0;
  int errors = 0;

  int         acc_cnt = 0;
  int         ovr_cnt = 0;
  int         brk_cnt = 0;
  logic [7:0] acc_data = 8'h00;
  logic       acc_perr = 1'b0;
  logic       acc_ferr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_HZ), .OVERSAMPLE(OS),
                 .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .I_rx_en(rx_en), .I_rs232_rxd(rxd[0]), .I_rx_ready(ready[0]),
    .O_rx_valid(valid[0]), .O_rx_data(d0), .O_parity_err(perr[0]), .O_frame_err(ferr[0]),
    .O_overrun(ovr[0]), .O_busy(busy[0]), .O_break(brk[0]));

  uart_rx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_HZ), .OVERSAMPLE(OS),
                 .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .I_rx_en(rx_en), .I_rs232_rxd(rxd[1]), .I_rx_ready(ready[1]),
    .O_rx_valid(valid[1]), .O_rx_data(d1), .O_parity_err(perr[1]), .O_frame_err(ferr[1]),
    .O_overrun(ovr[1]), .O_busy(busy[1]), .O_break(brk[1]));

  uart_rx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_HZ), .OVERSAMPLE(OS),
                 .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .I_rx_en(rx_en), .I_rs232_rxd(rxd[2]), .I_rx_ready(ready[2]),
    .O_rx_valid(valid[2]), .O_rx_data(d2), .O_parity_err(perr[2]), .O_frame_err(ferr[2]),
    .O_overrun(ovr[2]), .O_busy(busy[2]), .O_break(brk[2]));

  uart_rx_core #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_HZ), .OVERSAMPLE(OS),
                 .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .I_rx_en(rx_en), .I_rs232_rxd(rxd[3]), .I_rx_ready(ready[3]),
    .O_rx_valid(valid[3]), .O_rx_data(d3), .O_parity_err(perr[3]), .O_frame_err(ferr[3]),
    .O_overrun(ovr[3]), .O_busy(busy[3]), .O_break(brk[3]));

  // Event recorder for receiver 0: accepted words and output pulses.
  always @(posedge clk) begin
    if (valid[0] && ready[0]) begin
      acc_cnt  <= acc_cnt + 1;
      acc_data <= d0;
      acc_perr <= perr[0];
      acc_ferr <= ferr[0];
    end
    if (ovr[0]) ovr_cnt <= ovr_cnt + 1;
    if (brk[0]) brk_cnt <= brk_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives nbits line bits (LSB of pat first), 16 clk each; glitch_at inverts
  // the line for one clock at that clock index within the frame (-1 = none).
  task automatic applyStimulus(input int ch, input logic [15:0] pat, input int nbits,
                               input int glitch_at);
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < OS; c++) begin
        @(negedge clk);
        rxd[ch] = pat[i] ^ ((i * OS + c) == glitch_at);
      end
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drainWord(input int ch);
    @(negedge clk);
    ready[ch] = 1'b1;
    @(negedge clk);
    ready[ch] = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    rx_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rxd[k]   = 1'b1;
      ready[k] = 1'b0;
    end
    waitClocks(4);
    rst = 1'b0;
    waitClocks(1);

    $display("[TB] reset state");
    checkOutput("rst_valid", valid[0], 0);
    checkOutput("rst_busy",  busy[0],  0);
    checkOutput("rst_data",  d0,       0);
    checkOutput("rst_ferr",  ferr[0],  0);
    checkOutput("rst_ovr",   ovr[0],   0);
    checkOutput("rst_brk",   brk[0],   0);

    $display("[TB] 8N1 0xA5 with ready high");
    ready[0] = 1'b1;
    applyStimulus(0, {6'h3f, 1'b1, 8'hA5, 1'b0}, 10, -1);
    waitClocks(4);
    checkOutput("8n1_count", acc_cnt,  1);
    checkOutput("8n1_data",  acc_data, 8'hA5);
    checkOutput("8n1_perr",  acc_perr, 0);
    checkOutput("8n1_ferr",  acc_ferr, 0);
    checkOutput("8n1_drop",  valid[0], 0);

    $display("[TB] parity checks");
    applyStimulus(1, {5'h1f, 1'b1, 1'b0, 8'h37, 1'b0}, 11, -1);
    checkOutput("8e1_valid", valid[1], 1);
    checkOutput("8e1_data",  d1,       8'h37);
    checkOutput("8e1_perr",  perr[1],  1);
    checkOutput("8e1_ferr",  ferr[1],  0);
    drainWord(1);
    checkOutput("8e1_drain", valid[1], 0);
    applyStimulus(1, {5'h1f, 1'b1, 1'b1, 8'h37, 1'b0}, 11, -1);
    checkOutput("8e1_good_perr", perr[1], 0);
    applyStimulus(2, {5'h1f, 1'b1, 1'b0, 8'h37, 1'b0}, 11, -1);
    checkOutput("8o1_valid", valid[2], 1);
    checkOutput("8o1_data",  d2,       8'h37);
    checkOutput("8o1_perr",  perr[2],  0);

    $display("[TB] 7N2 with low second stop bit");
    applyStimulus(3, {6'h00, 1'b0, 1'b1, 7'h55, 1'b0}, 10, -1);
    checkOutput("7n2_valid", valid[3], 1);
    checkOutput("7n2_data",  d3,       7'h55);
    checkOutput("7n2_ferr",  ferr[3],  1);
    checkOutput("7n2_perr",  perr[3],  0);
    waitClocks(32);
    checkOutput("7n2_wait_high", busy[3], 1);
    rxd[3] = 1'b1;
    waitClocks(6);
    checkOutput("7n2_idle", busy[3], 0);

    $display("[TB] overrun");
    ready[0] = 1'b0;
    applyStimulus(0, {6'h3f, 1'b1, 8'h11, 1'b0}, 10, -1);
    checkOutput("ovr_first_valid", valid[0], 1);
    checkOutput("ovr_first_data",  d0,       8'h11);
    applyStimulus(0, {6'h3f, 1'b1, 8'h22, 1'b0}, 10, -1);
    waitClocks(2);
    checkOutput("ovr_pulses", ovr_cnt,  1);
    checkOutput("ovr_held",   d0,       8'h11);
    checkOutput("ovr_valid",  valid[0], 1);
    drainWord(0);
    checkOutput("ovr_drain",  valid[0], 0);
    checkOutput("ovr_taken",  acc_data, 8'h11);
    checkOutput("ovr_count",  acc_cnt,  2);

    $display("[TB] glitches");
    ready[0] = 1'b1;
    @(negedge clk);
    rxd[0] = 1'b0;
    waitClocks(2);
    rxd[0] = 1'b1;
    waitClocks(4);
    checkOutput("glitch_start", busy[0], 1);
    waitClocks(20);
    checkOutput("glitch_idle",  busy[0], 0);
    checkOutput("glitch_none",  acc_cnt, 2);
    applyStimulus(0, {6'h3f, 1'b1, 8'h5A, 1'b0}, 10, 4 * OS + 9);
    waitClocks(4);
    checkOutput("maj_count", acc_cnt,  3);
    checkOutput("maj_data",  acc_data, 8'h5A);
    checkOutput("maj_ferr",  acc_ferr, 0);

    $display("[TB] line held low for 15 bits");
    @(negedge clk);
    rxd[0] = 1'b0;
    waitClocks(15 * OS);
    checkOutput("brk_busy", busy[0], 1);
    rxd[0] = 1'b1;
    waitClocks(8);
    checkOutput("brk_idle", busy[0], 0);
`ifdef UART_RX_BREAK_DET_EN
    checkOutput("brk_pulses", brk_cnt, 1);
    checkOutput("brk_no_word", acc_cnt, 3);
`else
    checkOutput("brk_pulses", brk_cnt, 0);
    checkOutput("brk_word",   acc_cnt, 4);
    checkOutput("brk_data",   acc_data, 8'h00);
    checkOutput("brk_ferr",   acc_ferr, 1);
`endif

    $display("[TB] reset mid-frame");
    ready[0] = 1'b0;
    applyStimulus(0, {6'h3f, 1'b1, 8'h3C, 1'b0}, 10, -1);
    checkOutput("mid_held", d0, 8'h3C);
    applyStimulus(0, {6'h3f, 1'b1, 8'hF0, 1'b0}, 4, -1);
    checkOutput("mid_busy", busy[0], 1);
    @(negedge clk);
    rst    = 1'b1;
    rxd[0] = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_valid", valid[0], 0);
    checkOutput("mid_rst_busy",  busy[0],  0);
    checkOutput("mid_rst_data",  d0,       0);
    checkOutput("mid_rst_ferr",  ferr[0],  0);
    rst      = 1'b0;
    ready[0] = 1'b1;
    waitClocks(2);
    applyStimulus(0, {6'h3f, 1'b1, 8'h96, 1'b0}, 10, -1);
    waitClocks(4);
    checkOutput("recover_data", acc_data, 8'h96);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
